// File: rtl/channel_mailbox.sv
// Channel-addressed message buffer: 8 message slots matched against 4 listener registers.
// Optional build macro CHANNEL_MAILBOX_PERSIST_EN enables persistent listeners.
module channel_mailbox (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send_valid,
  output logic        send_ready,
  input  logic [7:0]  channel_id,
  input  logic [31:0] message_data,
  input  logic        listen_valid,
  output logic        listen_ready,
  input  logic [7:0]  listen_channel,
  input  logic        listen_persist,
  output logic        recv_valid,
  input  logic        recv_ready,
  output logic [7:0]  recv_channel_id,
  output logic [31:0] recv_message,
  output logic [1:0]  recv_listener,
  output logic [3:0]  msg_count,
  output logic [1:0]  state_debug
);

  typedef enum logic [1:0] {StIdle = 2'd0, StScan = 2'd1, StDeliver = 2'd2} state_e;

  state_e state_q, state_d;

  logic [7:0]       slot_valid_q, slot_valid_d;
  logic [7:0][7:0]  slot_ch_q, slot_ch_d;
  logic [7:0][31:0] slot_data_q, slot_data_d;
  logic [7:0][2:0]  slot_age_q, slot_age_d;
  logic [3:0]       lst_valid_q, lst_valid_d;
  logic [3:0][7:0]  lst_ch_q, lst_ch_d;
  logic [3:0]       lst_keep;
`ifdef CHANNEL_MAILBOX_PERSIST_EN
  logic [3:0]       lst_persist_q, lst_persist_d;
  assign lst_keep = lst_persist_q;
`else
  logic unused_persist;
  assign unused_persist = listen_persist;
  assign lst_keep = 4'b0;
`endif

  logic [2:0]  sel_slot_q;
  logic [7:0]  recv_ch_q;
  logic [31:0] recv_msg_q;
  logic [1:0]  recv_lst_q;

  logic [2:0] ins_idx, best_slot, best_age;
  logic [1:0] lst_idx, best_lst;
  logic       found, send_fire, listen_fire, deliver_fire;

  always_comb begin
    msg_count = 4'd0;
    for (int i = 0; i < 8; i++) msg_count = msg_count + {3'b0, slot_valid_q[i]};
  end

  assign send_ready   = (msg_count != 4'd8);
  assign listen_ready = ~&lst_valid_q;
  assign send_fire    = send_valid && send_ready;
  assign listen_fire  = listen_valid && listen_ready;
  assign deliver_fire = (state_q == StDeliver) && recv_ready;

  // Lowest free slot / listener, from registered state only.
  always_comb begin
    ins_idx = 3'd0;
    lst_idx = 2'd0;
    for (int i = 7; i >= 0; i--) if (!slot_valid_q[i]) ins_idx = 3'(i);
    for (int j = 3; j >= 0; j--) if (!lst_valid_q[j]) lst_idx = 2'(j);
  end

  // Oldest matching slot wins; strict compare keeps the lowest listener on ties.
  always_comb begin
    found     = 1'b0;
    best_slot = 3'd0;
    best_lst  = 2'd0;
    best_age  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (slot_valid_q[i] && lst_valid_q[j] && (slot_ch_q[i] == lst_ch_q[j]) &&
            (!found || (slot_age_q[i] > best_age))) begin
          found     = 1'b1;
          best_slot = 3'(i);
          best_lst  = 2'(j);
          best_age  = slot_age_q[i];
        end
      end
    end
  end

  // Removal is applied before insertion so ages stay a dense 0..count-1 ordering.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_ch_d    = slot_ch_q;
    slot_data_d  = slot_data_q;
    slot_age_d   = slot_age_q;
    if (deliver_fire) begin
      slot_valid_d[sel_slot_q] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (slot_valid_q[i] && (slot_age_q[i] > slot_age_q[sel_slot_q])) begin
          slot_age_d[i] = slot_age_q[i] - 3'd1;
        end
      end
    end
    if (send_fire) begin
      for (int i = 0; i < 8; i++) begin
        if (slot_valid_d[i]) slot_age_d[i] = slot_age_d[i] + 3'd1;
      end
      slot_valid_d[ins_idx] = 1'b1;
      slot_age_d[ins_idx]   = 3'd0;
      slot_ch_d[ins_idx]    = channel_id;
      slot_data_d[ins_idx]  = message_data;
    end
  end

  always_comb begin
    lst_valid_d = lst_valid_q;
    lst_ch_d    = lst_ch_q;
`ifdef CHANNEL_MAILBOX_PERSIST_EN
    lst_persist_d = lst_persist_q;
`endif
    if (deliver_fire && !lst_keep[recv_lst_q]) lst_valid_d[recv_lst_q] = 1'b0;
    if (listen_fire) begin
      lst_valid_d[lst_idx] = 1'b1;
      lst_ch_d[lst_idx]    = listen_channel;
`ifdef CHANNEL_MAILBOX_PERSIST_EN
      lst_persist_d[lst_idx] = listen_persist;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= '0;
      slot_ch_q    <= '0;
      slot_data_q  <= '0;
      slot_age_q   <= '0;
      lst_valid_q  <= '0;
      lst_ch_q     <= '0;
`ifdef CHANNEL_MAILBOX_PERSIST_EN
      lst_persist_q <= '0;
`endif
      sel_slot_q   <= '0;
      recv_ch_q    <= '0;
      recv_msg_q   <= '0;
      recv_lst_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_ch_q    <= slot_ch_d;
      slot_data_q  <= slot_data_d;
      slot_age_q   <= slot_age_d;
      lst_valid_q  <= lst_valid_d;
      lst_ch_q     <= lst_ch_d;
`ifdef CHANNEL_MAILBOX_PERSIST_EN
      lst_persist_q <= lst_persist_d;
`endif
      if ((state_q == StScan) && found) begin
        sel_slot_q <= best_slot;
        recv_ch_q  <= slot_ch_q[best_slot];
        recv_msg_q <= slot_data_q[best_slot];
        recv_lst_q <= best_lst;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if ((|slot_valid_q) && (|lst_valid_q)) state_d = StScan;
      StScan:    state_d = found ? StDeliver : StIdle;
      StDeliver: if (recv_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    recv_valid      = (state_q == StDeliver);
    state_debug     = state_q;
    recv_channel_id = recv_ch_q;
    recv_message    = recv_msg_q;
    recv_listener   = recv_lst_q;
  end

endmodule

// File: tb/tb_channel_mailbox.sv
// Scoreboard bench for channel_mailbox; the monitor checks every completed delivery.
module tb_channel_mailbox;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        send_valid = 1'b0;
  logic        send_ready;
  logic [7:0]  channel_id = '0;
  logic [31:0] message_data = '0;
  logic        listen_valid = 1'b0;
  logic        listen_ready;
  logic [7:0]  listen_channel = '0;
  logic        listen_persist = 1'b0;
  logic        recv_valid;
  logic        recv_ready = 1'b0;
  logic [7:0]  recv_channel_id;
  logic [31:0] recv_message;
  logic [1:0]  recv_listener;
  logic [3:0]  msg_count;
  logic [1:0]  state_debug;

  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] data;
    logic [1:0]  lst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  channel_mailbox dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .send_valid      (send_valid),
    .send_ready      (send_ready),
    .channel_id      (channel_id),
    .message_data    (message_data),
    .listen_valid    (listen_valid),
    .listen_ready    (listen_ready),
    .listen_channel  (listen_channel),
    .listen_persist  (listen_persist),
    .recv_valid      (recv_valid),
    .recv_ready      (recv_ready),
    .recv_channel_id (recv_channel_id),
    .recv_message    (recv_message),
    .recv_listener   (recv_listener),
    .msg_count       (msg_count),
    .state_debug     (state_debug)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && recv_valid && recv_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_recv: got ch 0x%0h data 0x%0h, none expected",
                 recv_channel_id, recv_message);
      end else begin
        mon_e = exp_q.pop_front();
        check("recv_channel_id", {24'b0, recv_channel_id}, {24'b0, mon_e.ch});
        check("recv_message", recv_message, mon_e.data);
        check("recv_listener", {30'b0, recv_listener}, {30'b0, mon_e.lst});
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    send_valid = 1'b0;
    listen_valid = 1'b0;
    idle(2);
    reset_n = 1'b1;
  endtask

  task automatic do_send(input logic [7:0] ch, input logic [31:0] d);
    int t = 0;
    send_valid = 1'b1;
    channel_id = ch;
    message_data = d;
    while (!send_ready && t < 50) begin idle(1); t++; end
    if (!send_ready) check("send_timeout", 32'(send_ready), 32'd1);
    idle(1);
    send_valid = 1'b0;
  endtask

  task automatic do_listen(input logic [7:0] ch, input logic persist);
    int t = 0;
    listen_valid = 1'b1;
    listen_channel = ch;
    listen_persist = persist;
    while (!listen_ready && t < 50) begin idle(1); t++; end
    if (!listen_ready) check("listen_timeout", 32'(listen_ready), 32'd1);
    idle(1);
    listen_valid = 1'b0;
  endtask

  // Ends on the falling edge where recv_valid is seen.
  task automatic wait_recv(input string name);
    int t = 0;
    @(negedge clk);
    while (!recv_valid && t < 50) begin @(negedge clk); t++; end
    check(name, 32'(recv_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    check("reset_send_ready", 32'(send_ready), 32'd1);
    check("reset_listen_ready", 32'(listen_ready), 32'd1);
    check("reset_recv_valid", 32'(recv_valid), 32'd0);
    check("reset_msg_count", 32'(msg_count), 32'd0);
    check("reset_state", 32'(state_debug), 32'd0);
    check("reset_recv_message", recv_message, 32'd0);
    check("reset_recv_ch", 32'(recv_channel_id), 32'd0);

    // Basic delivery with N+3 latency.
    recv_ready = 1'b1;
    do_listen(8'h05, 1'b0);
    idle(2);
    exp_q.push_back('{ch: 8'h05, data: 32'hDEADBEEF, lst: 2'd0});
    do_send(8'h05, 32'hDEADBEEF);
    @(negedge clk); check("lat_n1_recv_valid", 32'(recv_valid), 32'd0);
    @(negedge clk); check("lat_n2_recv_valid", 32'(recv_valid), 32'd0);
    @(negedge clk); check("lat_n3_recv_valid", 32'(recv_valid), 32'd1);
    @(posedge clk); #1;
    idle(2);
    check("basic_msg_count", 32'(msg_count), 32'd0);
    check("basic_listen_ready", 32'(listen_ready), 32'd1);

    // Full buffer.
    apply_reset();
    for (int i = 0; i < 8; i++) do_send(8'h01, 32'h100 + 32'(i));
    check("full_send_ready", 32'(send_ready), 32'd0);
    check("full_msg_count", 32'(msg_count), 32'd8);
    send_valid = 1'b1; channel_id = 8'h01; message_data = 32'h999;
    idle(1);
    send_valid = 1'b0;
    check("ninth_msg_count", 32'(msg_count), 32'd8);
    exp_q.push_back('{ch: 8'h01, data: 32'h100, lst: 2'd0});
    do_listen(8'h01, 1'b0);
    wait_recv("full_recv_seen");
    check("full_hs_send_ready", 32'(send_ready), 32'd0);
    @(negedge clk);
    check("after_hs_send_ready", 32'(send_ready), 32'd1);
    check("after_hs_msg_count", 32'(msg_count), 32'd7);
    @(posedge clk); #1;
    idle(3);
    check("full_pending", 32'(exp_q.size()), 32'd0);

    // Per-channel ordering and listener persistence.
    apply_reset();
    do_send(8'h02, 32'hA);
    do_send(8'h03, 32'hD);
    do_send(8'h02, 32'hB);
    do_send(8'h02, 32'hC);
    exp_q.push_back('{ch: 8'h02, data: 32'hA, lst: 2'd0});
`ifdef CHANNEL_MAILBOX_PERSIST_EN
    exp_q.push_back('{ch: 8'h02, data: 32'hB, lst: 2'd0});
    exp_q.push_back('{ch: 8'h02, data: 32'hC, lst: 2'd0});
`endif
    do_listen(8'h02, 1'b1);
    idle(30);
    check("order_pending", 32'(exp_q.size()), 32'd0);
`ifdef CHANNEL_MAILBOX_PERSIST_EN
    check("order_msg_count", 32'(msg_count), 32'd1);
    exp_q.push_back('{ch: 8'h02, data: 32'hE, lst: 2'd0});
    do_send(8'h02, 32'hE);
    idle(10);
    check("persist_msg_count", 32'(msg_count), 32'd1);
`else
    check("order_msg_count", 32'(msg_count), 32'd3);
    do_send(8'h02, 32'hE);
    idle(10);
    check("oneshot_msg_count", 32'(msg_count), 32'd4);
`endif
    check("order_state_idle", 32'(state_debug), 32'd0);
    check("order_pending_end", 32'(exp_q.size()), 32'd0);

    // Listener table full; lowest matching listener index wins.
    apply_reset();
    do_listen(8'h10, 1'b0);
    do_listen(8'h07, 1'b0);
    do_listen(8'h07, 1'b0);
    do_listen(8'h13, 1'b0);
    check("lst_full_ready", 32'(listen_ready), 32'd0);
    exp_q.push_back('{ch: 8'h07, data: 32'h77, lst: 2'd1});
    do_send(8'h07, 32'h77);
    idle(8);
    check("lst_freed_ready", 32'(listen_ready), 32'd1);
    check("lst_pending", 32'(exp_q.size()), 32'd0);

    // Stall in DELIVER, then simultaneous send and handshake.
    apply_reset();
    recv_ready = 1'b0;
    do_listen(8'h04, 1'b0);
    do_send(8'h04, 32'h44);
    wait_recv("stall_recv_seen");
    @(posedge clk); #1;
    do_send(8'h04, 32'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_recv_valid", 32'(recv_valid), 32'd1);
      check("stall_recv_ch", 32'(recv_channel_id), 32'h04);
      check("stall_recv_message", recv_message, 32'h44);
      check("stall_recv_listener", 32'(recv_listener), 32'd0);
    end
    @(posedge clk); #1;
    check("stall_msg_count", 32'(msg_count), 32'd2);
    exp_q.push_back('{ch: 8'h04, data: 32'h44, lst: 2'd0});
    recv_ready = 1'b1;
    send_valid = 1'b1; channel_id = 8'h09; message_data = 32'h99;
    idle(1);
    send_valid = 1'b0;
    check("simul_msg_count", 32'(msg_count), 32'd2);
    idle(3);
    check("simul_msg_count_later", 32'(msg_count), 32'd2);
    check("stall_pending", 32'(exp_q.size()), 32'd0);

    // Reset while a delivery is pending.
    apply_reset();
    recv_ready = 1'b0;
    do_listen(8'h06, 1'b0);
    do_send(8'h06, 32'h66);
    wait_recv("rst_recv_seen");
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_recv_valid", 32'(recv_valid), 32'd0);
    check("rst_state", 32'(state_debug), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    check("rst_msg_count", 32'(msg_count), 32'd0);
    check("rst_send_ready", 32'(send_ready), 32'd1);
    check("rst_listen_ready", 32'(listen_ready), 32'd1);
    check("rst_recv_message", recv_message, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_mailbox.md
CHANNEL_MAILBOX -- requirements
Module: channel_mailbox

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- send_valid  in  1  sender offers a message.
- send_ready  out  1  buffer can accept a message.
- channel_id  in  8  channel of the offered message.
- message_data  in  32  payload of the offered message.
- listen_valid  in  1  request to register a listener.
- listen_ready  out  1  a free listener register exists.
- listen_channel  in  8  channel to listen on.
- listen_persist  in  1  listener survives delivery.
- recv_valid  out  1  delivery offered.
- recv_ready  in  1  consumer accepts delivery.
- recv_channel_id  out  8  channel of the delivered message.
- recv_message  out  32  payload of the delivered message.
- recv_listener  out  2  index of the matched listener.
- msg_count  out  4  occupied message slots, 0..8.
- state_debug  out  2  FSM state.

Function
REQ-002 Storage SHALL be 8 message slots (valid, 8-bit channel, 32-bit data, 3-bit age) and 4 listener registers (valid, 8-bit channel, persist).
REQ-003 send_ready SHALL equal (msg_count != 8), computed from registered state; a slot freed in the same cycle does not raise it.
REQ-004 On send_valid && send_ready, the message SHALL go into the lowest-index free slot with age 0; every other valid slot's age increments.
REQ-005 listen_ready SHALL be high iff any listener register is free; on listen_valid && listen_ready, the lowest free register is loaded.
REQ-006 FSM states: IDLE=0, SCAN=1, DELIVER=2.
REQ-007 IDLE->SCAN when at least one slot is valid and at least one listener is valid.
REQ-008 In SCAN, the block SHALL select the valid (slot, listener) pair with equal channels, choosing highest slot age, then lowest listener index:
- match: latch recv_* outputs and go to DELIVER;
- no match: go to IDLE.
REQ-009 In DELIVER, recv_valid SHALL be 1 and recv_* outputs SHALL hold stable until recv_ready.
REQ-010 On recv_valid && recv_ready:
- free the slot;
- decrement ages greater than the freed slot's age;
- clear the listener unless its persist bit is set;
- go to IDLE.
REQ-011 A send and a delivery completing in the same cycle SHALL both take effect. Age updates apply removal first, then insertion. msg_count is unchanged in that cycle.
REQ-012 A listener registration in the same cycle as a delivery SHALL NOT load the register being freed that cycle.
REQ-013 The slot and listener latched for DELIVER SHALL NOT be overwritten until the delivery completes.
REQ-014 Latency: send accepted at cycle N with a matching listener already valid and FSM in IDLE -> recv_valid high at N+3.
REQ-015 Per channel, messages SHALL be delivered in acceptance order.

Reset
REQ-016 On reset_n low, asynchronously:
- all slot and listener valid bits = 0;
- FSM = IDLE;
- recv_valid = 0, recv_channel_id = 0, recv_message = 0, recv_listener = 0;
- msg_count = 0, state_debug = 0;
- send_ready = 1, listen_ready = 1.
REQ-017 Reset asserted during DELIVER SHALL discard the pending delivery with no handshake.

Configuration
REQ-018 Macro CHANNEL_MAILBOX_PERSIST_EN:
- defined: listen_persist is stored and honoured per REQ-010;
- undefined: listen_persist is ignored, no persist bit is synthesized, and every listener is one-shot.

Verification
REQ-019 Send ch 0x05 data 0xDEADBEEF at cycle N, listener ch 0x05 already valid, recv_ready=1 -> recv_valid at N+3 with 0xDEADBEEF, listener 0; afterwards msg_count=0 and listen_ready=1.
REQ-020 Send 8 messages on ch 0x01, no listener -> send_ready=0 and msg_count=8. A 9th send is not accepted. Register listener ch 0x01 -> first message is delivered; send_ready returns to 1 the cycle after the handshake.
REQ-021 Send A, B, C on ch 0x02 interleaved with D on ch 0x03, then register a persistent listener on ch 0x02 -> A, B, C delivered in order, D remains, listener still valid (with _PERSIST_EN).
REQ-022 Same as REQ-021 without _PERSIST_EN -> only A delivered, listener cleared, msg_count=3.
REQ-023 Hold recv_ready=0 for 10 cycles in DELIVER while sending on the same channel -> recv_* outputs stable throughout. The new send is stored and msg_count increments.
REQ-024 Assert reset_n low in DELIVER -> recv_valid=0 immediately; after release msg_count=0, send_ready=1, listen_ready=1.
